// File: rtl/capture_reader.sv
// Receives the capture stage's framed serial dump into a host-readable byte buffer.
// Requests the dump with a one-cycle sbf pulse and reports byte count and errors.
module capture_reader #(
    parameter int NBYTES  = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arm,
    input  logic          trd,
    input  logic          cd,
    input  logic          sd,
    output logic          sbf,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   byte_count,
    output logic          frame_err,
    output logic          timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   NB_W = (AW + 1)'(NBYTES);
    localparam logic [IW-1:0] TO_W = IW'(TIMEOUT);

    state_t        state_q, state_d;
    logic          sbf_q, sbf_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW:0]   byte_count_q, byte_count_d;
    logic          frame_err_q, frame_err_d;
    logic          timeout_err_q, timeout_err_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    rd_data_q;
    logic          we;

    logic [7:0] buf_mem [2**AW];

    always_comb begin
        state_d       = state_q;
        sbf_d         = sbf_q;
        busy_d        = busy_q;
        done_d        = done_q;
        byte_count_d  = byte_count_q;
        frame_err_d   = frame_err_q;
        timeout_err_d = timeout_err_q;
        bit_idx_d     = bit_idx_q;
        idle_cnt_d    = idle_cnt_q;
        shreg_d       = shreg_q;
        we            = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (arm && trd) begin
                    state_d       = S_REQ;
                    sbf_d         = 1'b1;
                    busy_d        = 1'b1;
                    done_d        = 1'b0;
                    byte_count_d  = '0;
                    frame_err_d   = 1'b0;
                    timeout_err_d = 1'b0;
                    idle_cnt_d    = '0;
                end
            end
            S_REQ: begin
                sbf_d      = 1'b0;
                idle_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (!sd) begin
                    state_d    = S_DATA;
                    bit_idx_d  = '0;
                    idle_cnt_d = '0;
                end else if (cd) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                    if (idle_cnt_d == TO_W) begin
                        state_d       = S_DONE;
                        done_d        = 1'b1;
                        busy_d        = 1'b0;
                        timeout_err_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                shreg_d   = {shreg_q[6:0], sd};
                bit_idx_d = bit_idx_q + 1'b1;
                if (bit_idx_q == 3'd7) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                idle_cnt_d = '0;
                if (sd) begin
                    we           = 1'b1;
                    byte_count_d = byte_count_q + 1'b1;
                    if (byte_count_d == NB_W) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    // a low stop bit is consumed here, never taken as a start bit
                    frame_err_d = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            sbf_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            byte_count_q  <= '0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            bit_idx_q     <= '0;
            idle_cnt_q    <= '0;
            shreg_q       <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            sbf_q         <= sbf_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            byte_count_q  <= byte_count_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
            bit_idx_q     <= bit_idx_d;
            idle_cnt_q    <= idle_cnt_d;
            shreg_q       <= shreg_d;
            rd_data_q     <= buf_mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            buf_mem[byte_count_q[AW-1:0]] <= shreg_q;
        end
    end

    assign sbf         = sbf_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign byte_count  = byte_count_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;
    assign rd_data     = rd_data_q;

endmodule

// File: doc/capture_reader.md
Name: capture_reader

Overview:
Downstream consumer of the trigger/sample-capture block's serial dump. When the capture stage reports a completed trigger (trd high) and the host arms this block, it issues a one-cycle send-buffer request (sbf). It then deserialises the framed bit stream on sd into a byte buffer that the host reads through a synchronous read port. Counts received bytes and flags framing and timeout errors. Single clock domain, one bit per clk.

Parameters:
NBYTES, 32, bytes expected per dump; transfer completes when this many are stored
AW, 5, buffer address width; NBYTES <= 2**AW
TIMEOUT, 64, consecutive idle-high cycles in WAIT_START before abort

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
arm  in  1  host request to fetch a dump; sampled only in IDLE/DONE
trd  in  1  trigger-data-ready from capture stage
cd  in  1  capture stage signals dump complete
sd  in  1  serial data from capture stage, idles high
sbf  out  1  send-buffer request pulse to capture stage
rd_addr  in  AW  buffer read address
rd_data  out  8  buffer read data, registered
busy  out  1  high from REQ until DONE/IDLE entered
done  out  1  transfer finished, held until next accepted arm or reset
byte_count  out  AW+1  bytes stored in current transfer
frame_err  out  1  sticky: at least one bad stop bit this transfer
timeout_err  out  1  sticky: transfer aborted by idle timeout

Behaviour:
- Frame format: start bit 0, 8 data bits MSB first, stop bit 1; one bit per clk sampled on rising edge.
- Reset (async): state IDLE; sbf, busy, done, frame_err, timeout_err = 0; byte_count = 0; rd_data = 0; bit index, idle counter, shift register cleared. Buffer contents not reset.
- States: IDLE, REQ, WAIT_START, DATA, STOP, DONE.
- IDLE/DONE: arm & trd -> REQ. arm & !trd -> ignored, state unchanged.
- REQ (exactly 1 cycle): sbf = 1. Clear byte_count, frame_err, timeout_err, done, idle counter. busy = 1. Next: WAIT_START.
- WAIT_START:
  - sd == 0 -> DATA, bit index = 0, idle counter = 0.
  - Else idle counter++. When it reaches TIMEOUT -> DONE with timeout_err = 1.
  - cd == 1 with sd == 1 -> DONE (no error).
  - Idle counter clears on every entry to WAIT_START.
- DATA: 8 cycles; shreg <= {shreg[6:0], sd}; after 8th bit -> STOP.
- STOP:
  - sd == 1: write shreg to buf[byte_count], byte_count++. If new count == NBYTES -> DONE, else WAIT_START.
  - sd == 0: byte discarded, frame_err = 1, -> WAIT_START. The stop-bit low is not reused as a start bit.
- DONE: done = 1, busy = 0; byte_count and errors held.
- sbf is never asserted outside REQ; it is registered and glitch-free.
- Read port:
  - rd_data <= buf[rd_addr] every cycle, in every state; 1-cycle latency.
  - Read and write to the same address in the same cycle return the old data (read-before-write).
- byte_count saturates at NBYTES; no further writes after DONE.
- Reset mid-transfer aborts immediately. A fresh arm afterwards starts a clean transfer.
- arm while busy is ignored.
- trd falling during a transfer has no effect.

Test Plan:
- Assert/release reset -> sbf=0, busy=0, done=0, byte_count=0, frame_err=0, timeout_err=0, rd_data=0.
- trd=1, arm pulse; source sends 32 good frames of bytes 0x00..0x1F -> sbf high exactly one cycle after arm; done=1 after 32nd stop bit; byte_count=32; rd_addr=5 gives rd_data=0x05 next cycle; rd_addr=31 gives 0x1F.
- trd=0, arm pulse -> sbf stays 0, busy stays 0, state IDLE; then trd=1 with arm -> transfer starts.
- Frame 0xD5 with stop bit 0, then good frame 0xA3 -> frame_err=1, byte_count=1, buf[0]=0xA3.
- 3 good frames (0x11, 0x22, 0x33), then sd held high 64 cycles -> timeout_err=1, done=1, byte_count=3. Separately, cd=1 after 3 frames -> done=1, timeout_err=0.
- Reset asserted during DATA of byte 10 -> all outputs 0 in same cycle; re-arm with trd=1 -> sbf pulse, byte_count restarts at 0.
